// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and small helpers for the register-file writeback arbiter.
// Supplies the project-wide `WORD_LEN / `REG_IDX_WIDTH / `RFREG_NUM / `WB_NUM_REQ
// defaults when no shared define file has set them first.
// Optional feature macro used by this slice: WB_FWD_EN.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif
`ifndef WB_NUM_REQ
`define WB_NUM_REQ 3
`endif

package regfile_wb_arbiter_pkg;

   localparam int WordLen     = `WORD_LEN;
   localparam int RegIdxWidth = `REG_IDX_WIDTH;
   localparam int RfRegNum    = `RFREG_NUM;
   localparam int WbNumReq    = `WB_NUM_REQ;

   // Width of a round-robin pointer over n requesters (at least one bit).
   function automatic int ptrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Next requester index after idx, wrapping at n.
   function automatic int wrapInc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the result producers and the register-file write port.
// master: requester/register-file side; slave: the arbiter.
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = WbNumReq,
   parameter int WORD_LEN      = WordLen,
   parameter int REG_IDX_WIDTH = RegIdxWidth
);

   logic [NUM_REQ-1:0]               reqValid;
   logic [NUM_REQ*REG_IDX_WIDTH-1:0] reqAddr;
   logic [NUM_REQ*WORD_LEN-1:0]      reqData;
   logic [NUM_REQ-1:0]               reqReady;
   logic                             wbHold;
   logic                             writeEnable;
   logic [REG_IDX_WIDTH-1:0]         writeAddr;
   logic [WORD_LEN-1:0]              writeData;

   modport master (
      output reqValid, reqAddr, reqData, wbHold,
      input  reqReady, writeEnable, writeAddr, writeData
   );

   modport slave (
      input  reqValid, reqAddr, reqData, wbHold,
      output reqReady, writeEnable, writeAddr, writeData
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found scanning
// ptr, ptr+1, ... modulo N. Kept generic so the memory port can reuse it.
module rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int N     = 3,
   parameter int PTR_W = ptrWidth(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             hold,
   output logic [N-1:0]     gnt
);

   localparam logic [N-1:0] One = N'(1);

   logic [2*N-1:0] reqDbl;
   logic [2*N-1:0] gntDbl;
   logic [N-1:0]   reqRot;
   logic [N-1:0]   gntRot;

   // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
   always_comb begin
      reqDbl = {req, req} >> ptr;
      reqRot = reqDbl[N-1:0];
      gntRot = reqRot & (~reqRot + One);
      gntDbl = {gntRot, gntRot} << ptr;
      gnt    = hold ? '0 : gntDbl[2*N-1:N];
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port between writeback sources,
// with one registered output stage and a per-register busy scoreboard.
// Optional feature macro: WB_FWD_EN (forwarding of the registered, not yet
// committed write onto fwdHit/fwdData; tied to 0 when undefined).
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = WbNumReq,
   parameter int WORD_LEN      = WordLen,
   parameter int REG_IDX_WIDTH = RegIdxWidth,
   parameter int RFREG_NUM     = RfRegNum
) (
   input  logic                     clk,
   input  logic                     rstn,
   regfile_wb_arbiter_if.slave      bus,
   input  logic                     issueValid,
   input  logic [REG_IDX_WIDTH-1:0] issueAddr,
   input  logic [REG_IDX_WIDTH-1:0] queryAddr1,
   input  logic [REG_IDX_WIDTH-1:0] queryAddr2,
   output logic                     busy1,
   output logic                     busy2,
   output logic                     protoErr,
   output logic                     fwdHit1,
   output logic                     fwdHit2,
   output logic [WORD_LEN-1:0]      fwdData1,
   output logic [WORD_LEN-1:0]      fwdData2
);

   localparam int PTR_W = ptrWidth(NUM_REQ);

   logic [PTR_W-1:0]         ptr;
   logic [PTR_W-1:0]         grantIdx;
   logic [NUM_REQ-1:0]       gnt;
   logic                     grant;
   logic [REG_IDX_WIDTH-1:0] grantAddr;
   logic [WORD_LEN-1:0]      grantData;
   logic [RFREG_NUM-1:0]     busy;
   logic [RFREG_NUM-1:0]     clearVec;
   logic [RFREG_NUM-1:0]     setVec;
   logic [RFREG_NUM-1:0]     busyNext;
   logic                     wawErr;
   logic                     grantErr;

   // Reset doubles as a hold so no requester sees a grant while rstn is low.
   rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) uArb (
      .req  (bus.reqValid),
      .ptr  (ptr),
      .hold (bus.wbHold | ~rstn),
      .gnt  (gnt)
   );

   assign bus.reqReady = gnt;
   assign grant        = |gnt;

   // Select the granted requester's index, destination and result.
   always_comb begin
      grantIdx  = '0;
      grantAddr = '0;
      grantData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            grantIdx  = PTR_W'(i);
            grantAddr = bus.reqAddr[i*REG_IDX_WIDTH +: REG_IDX_WIDTH];
            grantData = bus.reqData[i*WORD_LEN +: WORD_LEN];
         end
      end
   end

   // Pointer moves just past the winner; holds when nothing is granted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr <= '0;
      end else if (grant) begin
         ptr <= PTR_W'(wrapInc(int'(grantIdx), NUM_REQ));
      end
   end

   // Output stage: x0 grants are consumed but never reach the write port.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.writeEnable <= 1'b0;
         bus.writeAddr   <= '0;
         bus.writeData   <= '0;
      end else begin
         bus.writeEnable <= grant && (grantAddr != '0);
         if (grant) begin
            bus.writeAddr <= grantAddr;
            bus.writeData <= grantData;
         end
      end
   end

   // Scoreboard next state; a same-edge issue beats the clear (younger writer).
   always_comb begin
      clearVec = '0;
      setVec   = '0;
      if (grant && (grantAddr != '0)) clearVec[grantAddr] = 1'b1;
      if (issueValid && (issueAddr != '0)) setVec[issueAddr] = 1'b1;
      busyNext    = (busy & ~clearVec) | setVec;
      busyNext[0] = 1'b0;
      wawErr      = issueValid && (issueAddr != '0) && busy[issueAddr] && !clearVec[issueAddr];
      grantErr    = grant && (grantAddr != '0) && !busy[grantAddr];
   end

   // Busy bits register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy <= '0;
      end else begin
         busy <= busyNext;
      end
   end

   // Sticky protocol-violation flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         protoErr <= 1'b0;
      end else if (wawErr || grantErr) begin
         protoErr <= 1'b1;
      end
   end

   assign busy1 = (queryAddr1 != '0) && busy[queryAddr1];
   assign busy2 = (queryAddr2 != '0) && busy[queryAddr2];

`ifdef WB_FWD_EN
   assign fwdHit1  = bus.writeEnable && (bus.writeAddr == queryAddr1) && (queryAddr1 != '0);
   assign fwdHit2  = bus.writeEnable && (bus.writeAddr == queryAddr2) && (queryAddr2 != '0);
   assign fwdData1 = fwdHit1 ? bus.writeData : '0;
   assign fwdData2 = fwdHit2 ? bus.writeData : '0;
`else
   assign fwdHit1  = 1'b0;
   assign fwdHit2  = 1'b0;
   assign fwdData1 = '0;
   assign fwdData2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int N    = WbNumReq;
   localparam int AW   = RegIdxWidth;
   localparam int DW   = WordLen;
   localparam int NREG = RfRegNum;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          issueValid;
   logic [AW-1:0] issueAddr, queryAddr1, queryAddr2;
   logic          busy1, busy2, protoErr, fwdHit1, fwdHit2;
   logic [DW-1:0] fwdData1, fwdData2;

   regfile_wb_arbiter_if #(.NUM_REQ(N), .WORD_LEN(DW), .REG_IDX_WIDTH(AW)) bus ();

   regfile_wb_arbiter #(
      .NUM_REQ(N), .WORD_LEN(DW), .REG_IDX_WIDTH(AW), .RFREG_NUM(NREG)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .issueValid(issueValid), .issueAddr(issueAddr),
      .queryAddr1(queryAddr1), .queryAddr2(queryAddr2),
      .busy1(busy1), .busy2(busy2), .protoErr(protoErr),
      .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
      .fwdData1(fwdData1), .fwdData2(fwdData2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Register file fed by the DUT write port, committing on the falling edge.
   logic [DW-1:0] rf [NREG];
   always @(negedge clk) if (bus.writeEnable === 1'b1) rf[bus.writeAddr] = bus.writeData;

   // Behavioural model state.
   int            mPtr;
   bit            mBusy [NREG];
   bit            mWe;
   int            mWa;
   logic [DW-1:0] mWd;
   bit            mErr;

   task automatic modelReset();
      mPtr = 0; mWe = 0; mWa = 0; mWd = '0; mErr = 0;
      foreach (mBusy[i]) mBusy[i] = 0;
   endtask

   function automatic int modelGrant();
      if (bus.wbHold || !rstn) return -1;
      for (int k = 0; k < N; k++) begin
         int i = (mPtr + k) % N;
         if (bus.reqValid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] expReady();
      logic [N-1:0] e = '0;
      int g = modelGrant();
      if (g >= 0) e[g] = 1'b1;
      return e;
   endfunction

   function automatic bit expBusy(input int q);
      return (q != 0) && mBusy[q];
   endfunction

   function automatic bit expFwdHit(input int q);
`ifdef WB_FWD_EN
      return mWe && (mWa == q) && (q != 0);
`else
      return (q < 0);
`endif
   endfunction

   function automatic logic [DW-1:0] expFwdData(input int q);
      return expFwdHit(q) ? mWd : '0;
   endfunction

   // Advance the model across the coming rising edge using the driven inputs.
   task automatic modelEdge();
      int g = modelGrant();
      int clrAddr = -1;
      int ia = int'(issueAddr);
      if (g >= 0) begin
         int ga = int'(bus.reqAddr[g*AW +: AW]);
         mPtr = (g + 1) % N;
         mWe  = (ga != 0);
         mWa  = ga;
         mWd  = bus.reqData[g*DW +: DW];
         if (ga != 0) begin
            if (!mBusy[ga]) mErr = 1;
            clrAddr = ga;
         end
      end else begin
         mWe = 0;
      end
      if (issueValid && ia != 0 && mBusy[ia] && clrAddr != ia) mErr = 1;
      if (clrAddr > 0) mBusy[clrAddr] = 0;
      if (issueValid && ia != 0) mBusy[ia] = 1;
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.reqValid = '0; bus.reqAddr = '0; bus.reqData = '0; bus.wbHold = 1'b0;
      issueValid = 1'b0; issueAddr = '0; queryAddr1 = '0; queryAddr2 = '0;
   endtask

   task automatic setReq(input int i, input int a, input logic [DW-1:0] d);
      bus.reqValid[i] = 1'b1;
      bus.reqAddr[i*AW +: AW] = AW'(a);
      bus.reqData[i*DW +: DW] = d;
   endtask

   task automatic doReset();
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      modelReset();
   endtask

   task automatic test_reset();
      idle();
      setReq(0, 0, 32'h1);
      #1;
      checks++; if (bus.reqReady !== '0) begin errors++; $display("FAIL reset_ready: got %b need 0", bus.reqReady); end
      checks++; if (bus.writeEnable !== 1'b0 || bus.writeAddr !== '0 || bus.writeData !== '0) begin
         errors++; $display("FAIL reset_write: got we=%b a=%0d d=%h need 0/0/0", bus.writeEnable, bus.writeAddr, bus.writeData); end
      @(negedge clk);
      rstn = 1'b1;
      modelReset();
      idle();
      issueValid = 1'b1; issueAddr = AW'(4);
      tick();
      idle();
      setReq(0, 4, 32'h55);
      issueValid = 1'b1; issueAddr = AW'(8);
      tick();
      idle();
      setReq(0, 4, 32'h55);
      queryAddr1 = AW'(8);
      #1;
      checks++; if (bus.writeEnable !== mWe || busy1 !== expBusy(8)) begin
         errors++; $display("FAIL pre_reset_state: got we=%b busy1=%b need %b/%b", bus.writeEnable, busy1, mWe, expBusy(8)); end
      #1;
      rstn = 1'b0;
      #1;
      checks++; if (bus.writeEnable !== 1'b0 || busy1 !== 1'b0 || protoErr !== 1'b0 || bus.writeAddr !== '0) begin
         errors++; $display("FAIL async_reset: got we=%b busy1=%b err=%b a=%0d need 0/0/0/0", bus.writeEnable, busy1, protoErr, bus.writeAddr); end
      checks++; if (bus.reqReady !== '0) begin errors++; $display("FAIL reset_ready_mid: got %b need 0", bus.reqReady); end
      modelReset();
      @(negedge clk);
      #1;
      checks++; if (rf[4] === 32'h55) begin errors++; $display("FAIL reset_discard: x4 got %h, write should be dropped", rf[4]); end
      rstn = 1'b1;
      idle();
      setReq(0, 0, 32'h1); setReq(1, 0, 32'h2); setReq(2, 0, 32'h3);
      #1;
      checks++; if (bus.reqReady !== 3'b001 || bus.reqReady !== expReady()) begin
         errors++; $display("FAIL reset_first_grant: got %b need 001", bus.reqReady); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] er;
      doReset();
      idle();
      for (int r = 5; r <= 7; r++) begin
         issueValid = 1'b1; issueAddr = AW'(r);
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         idle();
         setReq(0, 5, 32'hAAAA_0000); setReq(1, 6, 32'hBBBB_0000); setReq(2, 7, 32'hCCCC_0000);
         issueValid = 1'b1; issueAddr = AW'(5 + (k % 3));
         #1;
         er = '0; er[k % 3] = 1'b1;
         checks++; if (bus.reqReady !== er || bus.reqReady !== expReady()) begin
            errors++; $display("FAIL rr_grant k=%0d: got %b need %b", k, bus.reqReady, er); end
         tick();
         checks++; if (bus.writeEnable !== 1'b1 || bus.writeAddr !== AW'(5 + (k % 3)) || bus.writeData !== mWd) begin
            errors++; $display("FAIL rr_write k=%0d: got we=%b a=%0d d=%h need 1/%0d/%h", k, bus.writeEnable, bus.writeAddr, bus.writeData, 5 + (k % 3), mWd); end
      end
      checks++; if (protoErr !== 1'b0) begin errors++; $display("FAIL rr_protoErr: got %b need 0", protoErr); end
   endtask

   task automatic test_scoreboard();
      doReset();
      idle();
      issueValid = 1'b1; issueAddr = AW'(9);
      queryAddr1 = AW'(9);
      #1;
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_no_bypass: got %b need 0", busy1); end
      tick();
      idle();
      queryAddr1 = AW'(9);
      #1;
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_set: got %b need 1", busy1); end
      setReq(1, 9, 32'hDEADBEEF);
      #1;
      checks++; if (bus.reqReady !== 3'b010) begin errors++; $display("FAIL sb_grant: got %b need 010", bus.reqReady); end
      tick();
      idle();
      queryAddr1 = AW'(9);
      #1;
      checks++; if (busy1 !== 1'b0 || bus.writeEnable !== 1'b1 || bus.writeAddr !== AW'(9)) begin
         errors++; $display("FAIL sb_clear: got busy1=%b we=%b a=%0d need 0/1/9", busy1, bus.writeEnable, bus.writeAddr); end
      @(negedge clk);
      #1;
      checks++; if (rf[9] !== 32'hDEADBEEF) begin errors++; $display("FAIL sb_readback: x9 got %h need deadbeef", rf[9]); end
   endtask

   task automatic test_simultaneous();
      doReset();
      idle();
      issueValid = 1'b1; issueAddr = AW'(9);
      tick();
      idle();
      setReq(2, 9, 32'h1);
      issueValid = 1'b1; issueAddr = AW'(9);
      tick();
      idle();
      queryAddr1 = AW'(9);
      #1;
      checks++; if (busy1 !== 1'b1 || protoErr !== 1'b0) begin
         errors++; $display("FAIL simul_set_wins: got busy1=%b err=%b need 1/0", busy1, protoErr); end
      issueValid = 1'b1; issueAddr = AW'(9);
      tick();
      idle();
      #1;
      checks++; if (protoErr !== 1'b1 || protoErr !== mErr) begin
         errors++; $display("FAIL simul_waw: got err=%b need 1", protoErr); end
   endtask

   task automatic test_x0_hold();
      doReset();
      idle();
      setReq(0, 0, 32'h77);
      #1;
      checks++; if (bus.reqReady !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b need 001", bus.reqReady); end
      tick();
      idle();
      #1;
      checks++; if (bus.writeEnable !== 1'b0 || bus.reqReady !== '0) begin
         errors++; $display("FAIL x0_no_write: got we=%b rdy=%b need 0/0", bus.writeEnable, bus.reqReady); end
      for (int k = 0; k < 3; k++) begin
         idle();
         setReq(0, 0, 32'h0); setReq(1, 0, 32'h0); setReq(2, 0, 32'h0);
         bus.wbHold = 1'b1;
         #1;
         checks++; if (bus.reqReady !== '0) begin errors++; $display("FAIL hold_ready k=%0d: got %b need 0", k, bus.reqReady); end
         tick();
      end
      bus.wbHold = 1'b0;
      #1;
      checks++; if (bus.reqReady !== 3'b010 || bus.reqReady !== expReady()) begin
         errors++; $display("FAIL hold_ptr: got %b need 010", bus.reqReady); end
      tick();
   endtask

   task automatic test_fwd();
      doReset();
      idle();
      issueValid = 1'b1; issueAddr = AW'(3);
      tick();
      idle();
      setReq(0, 3, 32'h1234);
      tick();
      idle();
      queryAddr1 = AW'(5); queryAddr2 = AW'(3);
      #1;
`ifdef WB_FWD_EN
      checks++; if (fwdHit2 !== 1'b1 || fwdData2 !== 32'h1234) begin
         errors++; $display("FAIL fwd_hit: got hit=%b data=%h need 1/1234", fwdHit2, fwdData2); end
`else
      checks++; if (fwdHit2 !== 1'b0 || fwdData2 !== '0) begin
         errors++; $display("FAIL fwd_off: got hit=%b data=%h need 0/0", fwdHit2, fwdData2); end
`endif
      checks++; if (fwdHit1 !== 1'b0 || fwdData1 !== '0 || busy2 !== 1'b0) begin
         errors++; $display("FAIL fwd_other: got hit1=%b data1=%h busy2=%b need 0/0/0", fwdHit1, fwdData1, busy2); end
      tick();
   endtask

   task automatic test_random();
      int q1, q2;
      doReset();
      for (int c = 0; c < 300; c++) begin
         if (c % 25 == 0 || $urandom_range(0, 49) == 0) doReset();
         idle();
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) != 0)
               setReq(i, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7)), $urandom);
         bus.wbHold = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 2) == 0) begin
            issueValid = 1'b1; issueAddr = AW'($urandom_range(0, 7));
         end
         q1 = int'($urandom_range(0, 7)); q2 = int'($urandom_range(0, 7));
         queryAddr1 = AW'(q1); queryAddr2 = AW'(q2);
         #1;
         checks++; if (bus.reqReady !== expReady()) begin
            errors++; $display("FAIL rand_ready c=%0d: got %b need %b", c, bus.reqReady, expReady()); end
         checks++; if (busy1 !== expBusy(q1) || busy2 !== expBusy(q2)) begin
            errors++; $display("FAIL rand_busy c=%0d: got %b%b need %b%b", c, busy1, busy2, expBusy(q1), expBusy(q2)); end
         checks++; if (protoErr !== mErr) begin
            errors++; $display("FAIL rand_protoErr c=%0d: got %b need %b", c, protoErr, mErr); end
         checks++; if (bus.writeEnable !== mWe || bus.writeAddr !== AW'(mWa) || bus.writeData !== mWd) begin
            errors++; $display("FAIL rand_write c=%0d: got %b/%0d/%h need %b/%0d/%h", c, bus.writeEnable, bus.writeAddr, bus.writeData, mWe, mWa, mWd); end
         checks++; if (fwdHit1 !== expFwdHit(q1) || fwdData1 !== expFwdData(q1) || fwdHit2 !== expFwdHit(q2) || fwdData2 !== expFwdData(q2)) begin
            errors++; $display("FAIL rand_fwd c=%0d: got %b/%h %b/%h need %b/%h %b/%h", c, fwdHit1, fwdData1, fwdHit2, fwdData2,
                               expFwdHit(q1), expFwdData(q1), expFwdHit(q2), expFwdData(q2)); end
         tick();
      end
   endtask

   initial begin
      foreach (rf[i]) rf[i] = '0;
      modelReset();
      test_reset();
      test_round_robin();
      test_scoreboard();
      test_simultaneous();
      test_x0_hold();
      test_fwd();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (writeEnable/writeAddr/writeData, committed on the falling edge) between NUM_REQ writeback sources, e.g. ALU, load unit and multi-cycle divider.
- Arbitration is round-robin, with one registered output stage feeding the register file.
- Keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards against writes still in flight.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- WORD_LEN, 32, data width (`WORD_LEN).
- REG_IDX_WIDTH, 5, register index width (`REG_IDX_WIDTH).
- RFREG_NUM, 32, register count (`RFREG_NUM).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- reqValid  in  NUM_REQ  requester i has a writeback pending.
- reqAddr  in  NUM_REQ*REG_IDX_WIDTH  destination of requester i, slice i.
- reqData  in  NUM_REQ*WORD_LEN  result of requester i, slice i.
- reqReady  out  NUM_REQ  one-hot grant; transfer when reqValid[i] && reqReady[i].
- wbHold  in  1  pipeline stall; no grant while high.
- writeEnable  out  1  to the register-file write port; registered.
- writeAddr  out  REG_IDX_WIDTH  registered.
- writeData  out  WORD_LEN  registered.
- issueValid  in  1  decode issues an instruction writing issueAddr.
- issueAddr  in  REG_IDX_WIDTH  destination being issued.
- queryAddr1, queryAddr2  in  REG_IDX_WIDTH each  source registers under test.
- busy1, busy2  out  1 each  combinational busy bit of queryAddr1/2; always 0 for x0.
- protoErr  out  1  sticky flag for a protocol violation.
- fwdHit1, fwdHit2  out  1 each  forwarding hit (WB_FWD_EN).
- fwdData1, fwdData2  out  WORD_LEN each  forwarding data (WB_FWD_EN).

Behaviour:
- Reset (rstn low, asynchronous):
  - writeEnable=0, writeAddr=0, writeData=0.
  - RR pointer=0.
  - All busy bits=0.
  - protoErr=0.
  - reqReady=0 while rstn is low.
  - Reset mid-transfer discards the held write; a write whose falling edge falls inside reset does not occur, because writeEnable is already 0.
- Grant (combinational):
  - If wbHold=1, reqReady=0.
  - Otherwise grant the first i with reqValid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - reqReady depends only on reqValid, ptr and wbHold; never on reqData.
- Pointer: after a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Output stage, every rising edge:
  - writeEnable <= grant && grantAddr != 0.
  - writeAddr/writeData <= the granted slice; they hold when there is no grant.
  - Latency: the write is accepted at edge N, driven during cycle N..N+1, and committed on the falling edge in cycle N.
  - Throughput: one write per cycle; the stage never back-pressures.
- Address 0: the grant is consumed and the requester is released, but writeEnable stays 0 and no busy bit changes.
- Scoreboard, busy[RFREG_NUM], with bit 0 constant 0:
  - Set on issueValid with issueAddr != 0.
  - Cleared at the edge where a grant to that address is accepted.
  - Same edge set and clear on the same register: set wins, because the issuing instruction is younger.
- protoErr is set and held until reset on either violation:
  - issueValid to an address that is already busy and not being cleared that edge (WAW).
  - A grant to a nonzero address whose busy bit is 0.
- busy1/busy2 reflect register state only; there is no same-cycle bypass from issueValid.

Optional Feature:
- Macro WB_FWD_EN.
- Defined:
  - fwdHitK = writeEnable && writeAddr == queryAddrK && queryAddrK != 0.
  - fwdDataK = writeData when fwdHitK=1, else 0.
  - Purpose: covers the write that is registered but not yet committed.
- Undefined: fwdHit1/2 and fwdData1/2 are tied to 0. Ports remain so the interface is identical.

Decomposition:
- Shared defines: `WORD_LEN, `REG_IDX_WIDTH, `RFREG_NUM in defines.v.
- Add `WB_NUM_REQ (default 3) to defines.v.
- Sub-module rr_arbiter (parameter N): inputs req, ptr, hold; output one-hot gnt; purely combinational, reusable for the memory port.
- Scoreboard, pointer and output stage stay in the top module.

Test Plan:
- Reset: assert rstn=0 mid-stream with req0 valid → writeEnable=0, busy=0, protoErr=0 immediately; first grant after release goes to req0.
- Round-robin: all three valid continuously, addrs 5/6/7, data A/B/C → grants 0,1,2,0,…; writeAddr sequence 5,6,7,5 on consecutive cycles.
- Scoreboard:
  - issue x9, query x9 → busy1=1 next cycle.
  - req1 writes x9=0xDEADBEEF → busy1=0 the cycle after the grant.
  - Register-file readback of x9 gives 0xDEADBEEF.
- Simultaneous events:
  - Grant clears x9 in the same edge that issues x9 → busy stays 1, protoErr=0.
  - Issue x9 again while busy with no clear → protoErr=1.
- x0 and hold:
  - Grant to addr 0 → reqReady pulses, writeEnable=0.
  - wbHold=1 for 3 cycles → reqReady=0, ptr unchanged.
- WB_FWD_EN: write x3=0x1234 registered with queryAddr2=3 → fwdHit2=1, fwdData2=0x1234. With the macro off, both are 0.
